// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard / stall controller.
// Contents: controller state enum, register-specifier width, stall counter width.
// Imported by pipe_hazard_ctrl and mem_wait_timer.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled data-memory cycles and flags the timeout point.
// Ports: clk_i/rst_i; mstall_i (stall this cycle, already gated off in ERROR);
//        in_wait_i (controller in MEM_WAIT); timeout_o (this edge enters ERROR).
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mstall_i,
    input  logic in_wait_i,
    output logic timeout_o
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    // The first stalled cycle happens in RUN and loads 1 on its closing edge,
    // so wait_cnt_q equals the number of stalled cycles already completed.
    always_comb begin
        wait_cnt_d = '0;
        if (mstall_i) begin
            wait_cnt_d = in_wait_i ? (wait_cnt_q + 8'd1) : 8'd1;
        end
    end

    // The edge closing the TIMEOUT_CYCLES-th consecutive stalled cycle.
    assign timeout_o = mstall_i && (wait_cnt_q == LAST_WAIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch,
// memory wait with timeout. Ports: hazard inputs from ID/EX/MEM, pipeline
// register enables/flush/bubble outputs, sticky error_o and stall_cnt_o.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int REG_ADDR_W     = pipe_ctrl_pkg::REG_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [REG_ADDR_W-1:0]  id_rs_i,
    input  logic [REG_ADDR_W-1:0]  id_rt_i,
    input  logic                   id_uses_rt_i,
    input  logic                   ex_memread_i,
    input  logic [REG_ADDR_W-1:0]  ex_rt_i,
    input  logic                   branch_taken_i,
    input  logic                   mem_req_i,
    input  logic                   mem_ack_i,
    output logic                   pc_we_o,
    output logic                   ifid_we_o,
    output logic                   ifid_flush_o,
    output logic                   idex_we_o,
    output logic                   idex_bubble_o,
    output logic                   exmem_we_o,
    output logic                   memwb_bubble_o,
    output logic                   error_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    ctrl_state_e            state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   mstall;
    logic                   luse;
    logic                   timeout;

    assign mstall = mem_req_i && !mem_ack_i && (state_q != ERROR);

    // A load into $zero never creates a real dependency.
    assign luse = ex_memread_i && (ex_rt_i != '0) &&
                  ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .mstall_i  (mstall),
        .in_wait_i (state_q == MEM_WAIT),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (timeout) state_d = ERROR;
                      else if (mstall) state_d = MEM_WAIT;
            MEM_WAIT: if (timeout) state_d = ERROR;
                      else if (!mstall) state_d = RUN;
            ERROR:    state_d = ERROR;
            default:  state_d = RUN;
        endcase
    end

    // Outputs are combinational so that reset and stall release act in the
    // same cycle; reset forces a fully flushed, frozen pipeline.
    always_comb begin
        pc_we_o        = 1'b1;
        ifid_we_o      = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_we_o      = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_we_o     = 1'b1;
        memwb_bubble_o = 1'b0;
        error_o        = 1'b0;
        if (!rst_i) begin
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            ifid_flush_o   = 1'b1;
            idex_we_o      = 1'b0;
            idex_bubble_o  = 1'b1;
            exmem_we_o     = 1'b0;
            memwb_bubble_o = 1'b1;
        end else if (state_q == ERROR) begin
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            idex_we_o      = 1'b0;
            idex_bubble_o  = 1'b1;
            exmem_we_o     = 1'b0;
            memwb_bubble_o = 1'b1;
            error_o        = 1'b1;
        end else if (mstall) begin
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            idex_we_o      = 1'b0;
            exmem_we_o     = 1'b0;
            memwb_bubble_o = 1'b1;
        end else if (luse) begin
            // The branch operand may depend on the load: drop any branch.
            pc_we_o        = 1'b0;
            ifid_we_o      = 1'b0;
            idex_bubble_o  = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o   = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// every cycle compared against a rule-level reference model.
// Ports: drives all DUT inputs, observes all DUT outputs.
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
    logic        id_uses_rt_i, ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;
    logic        pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o;
    logic        exmem_we_o, memwb_bubble_o, error_o;
    logic [15:0] stall_cnt_o;

    int vectors = 0;
    int fails   = 0;

    // Reference model: sticky error, consecutive stalled-cycle count, stall total.
    bit m_err    = 1'b0;
    int m_consec = 0;
    int m_stall  = 0;

    pipe_hazard_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .REG_ADDR_W     (5)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_uses_rt_i   (id_uses_rt_i),
        .ex_memread_i   (ex_memread_i),
        .ex_rt_i        (ex_rt_i),
        .branch_taken_i (branch_taken_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .pc_we_o        (pc_we_o),
        .ifid_we_o      (ifid_we_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_we_o      (idex_we_o),
        .idex_bubble_o  (idex_bubble_o),
        .exmem_we_o     (exmem_we_o),
        .memwb_bubble_o (memwb_bubble_o),
        .error_o        (error_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic setin(input bit rst, input int rs, input int rt, input bit uses,
                         input bit memrd, input int exrt, input bit br,
                         input bit req, input bit ack);
        rst_i          = rst;
        id_rs_i        = 5'(rs);
        id_rt_i        = 5'(rt);
        id_uses_rt_i   = uses;
        ex_memread_i   = memrd;
        ex_rt_i        = 5'(exrt);
        branch_taken_i = br;
        mem_req_i      = req;
        mem_ack_i      = ack;
    endtask

    function automatic logic [7:0] observed();
        return {pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o,
                idex_bubble_o, exmem_we_o, memwb_bubble_o, error_o};
    endfunction

    // Bit order: pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_bubble, error
    function automatic logic [7:0] expected(input bit ms, input bit lu);
        if (!rst_i)              return 8'b0010_1010;
        else if (m_err)          return 8'b0000_1011;
        else if (ms)             return 8'b0000_0010;
        else if (lu)             return 8'b0001_1100;
        else if (branch_taken_i) return 8'b1111_0100;
        else                     return 8'b1101_0100;
    endfunction

    // Called at posedge+1; compares mid-cycle, then advances the model over the edge.
    task automatic check(input string tag);
        bit         ms, lu;
        logic [7:0] exp_v, obs_v;
        #3;
        if (!rst_i) begin
            m_err = 1'b0; m_consec = 0; m_stall = 0;
        end
        ms = mem_req_i && !mem_ack_i && !m_err;
        lu = ex_memread_i && (ex_rt_i != 0) &&
             (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
        exp_v = expected(ms, lu);
        obs_v = observed();
        vectors++;
        assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs_v, exp_v);
        end
        vectors++;
        assert (stall_cnt_o === 16'(m_stall)) else begin
            fails++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt_o, m_stall);
        end
        @(posedge clk_i);
        if (rst_i) begin
            if (!m_err) begin
                if (ms) begin
                    m_consec++;
                    if (m_consec >= TMO) m_err = 1'b1;
                end else begin
                    m_consec = 0;
                end
            end
            if (!exp_v[7] && m_stall < 65535) m_stall++;
        end
        #1;
    endtask

    // Asynchronous reset assertion in the middle of a cycle.
    task automatic areset(input string tag);
        logic [7:0] obs_v;
        #2;
        rst_i = 1'b0;
        #1;
        obs_v = observed();
        vectors++;
        assert (obs_v === 8'b0010_1010) else begin
            fails++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs_v, 8'b0010_1010);
        end
        vectors++;
        assert (stall_cnt_o === 16'd0) else begin
            fails++;
            $error("FAIL %s stall_cnt observed=%0d expected=0", tag, stall_cnt_o);
        end
        m_err = 1'b0; m_consec = 0; m_stall = 0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        check("reset_hold");
        setin(0, 0, 0, 0, 0, 0, 1, 1, 0);
        check("reset_hold_busy");
        setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_release");

        // Load-use on rs: one stall cycle, then the bubble has left EX.
        setin(1, 8, 3, 0, 1, 8, 0, 0, 0);
        check("luse_rs");
        setin(1, 8, 3, 0, 0, 8, 0, 0, 0);
        check("luse_after");
        setin(1, 2, 9, 1, 1, 9, 0, 0, 0);
        check("luse_rt");

        // $zero and unused rt never stall.
        setin(1, 0, 0, 0, 1, 0, 0, 0, 0);
        check("zero_reg");
        setin(1, 3, 8, 0, 1, 8, 0, 0, 0);
        check("rt_unused");

        // Taken branch, then branch together with load-use.
        setin(1, 1, 2, 1, 0, 0, 1, 0, 0);
        check("branch");
        setin(1, 8, 2, 1, 1, 8, 1, 0, 0);
        check("branch_luse");
        setin(1, 1, 2, 1, 0, 0, 0, 0, 0);
        check("branch_done");

        // Three stalled memory cycles then ack.
        for (int i = 0; i < 3; i++) begin
            setin(1, 1, 2, 1, 0, 0, 1, 1, 0);
            check("mem_wait");
        end
        setin(1, 1, 2, 1, 0, 0, 0, 1, 1);
        check("mem_ack");
        setin(1, 1, 2, 0, 0, 0, 0, 0, 0);
        check("mem_idle");

        // Load-use held during a memory wait surfaces only after release.
        for (int i = 0; i < 2; i++) begin
            setin(1, 5, 0, 0, 1, 5, 0, 1, 0);
            check("mem_wait_luse");
        end
        setin(1, 5, 0, 0, 1, 5, 0, 1, 1);
        check("mem_ack_luse");
        setin(1, 5, 0, 0, 1, 5, 0, 0, 0);
        check("luse_released");
        setin(1, 5, 0, 0, 0, 5, 0, 1, 1);
        check("req_ack_same");
        setin(1, 5, 0, 0, 0, 5, 0, 1, 0);
        check("req_drop_a");
        setin(1, 5, 0, 0, 0, 5, 0, 0, 0);
        check("req_drop_b");

        // Timeout into ERROR; a late ack does not recover.
        for (int i = 0; i < TMO + 2; i++) begin
            setin(1, 1, 1, 0, 0, 0, 0, 1, 0);
            check("timeout");
        end
        setin(1, 1, 1, 0, 0, 0, 1, 1, 1);
        check("err_late_ack");
        setin(1, 1, 1, 0, 0, 0, 0, 0, 0);
        check("err_idle");
        areset("reset_in_error");
        setin(1, 1, 1, 0, 0, 0, 0, 1, 1);
        check("post_reset_req_ack");

        // Reset in the middle of a memory wait.
        for (int i = 0; i < 2; i++) begin
            setin(1, 1, 1, 0, 0, 0, 0, 1, 0);
            check("wait_pre_reset");
        end
        areset("reset_in_wait");
        setin(1, 1, 1, 0, 0, 0, 0, 1, 1);
        check("post_reset2_req_ack");
        setin(1, 1, 1, 0, 0, 0, 0, 1, 0);
        check("post_reset2_wait");

        // Random traffic over a small register range to force collisions.
        for (int i = 0; i < 600; i++) begin
            setin(($urandom_range(0, 63) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  1'($urandom), $urandom_range(0, 3), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
            check("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
